if_id_skid_reg: RTL
===================

IF_ID_SKID_REG -- requirements
Module: if_id_skid_reg

Interface
REQ-001 Parameter ADDR_W, default 32, width of the instruction-address field.
REQ-002 Parameter INST_W, default 32, width of the instruction field.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-low reset (rst==0 resets); sampled asynchronously, released synchronously by the integrator.
REQ-005 flush  input  1  synchronous discard of all held and incoming entries.
REQ-006 if_valid  input  1  upstream entry present.
REQ-007 if_pc  input  ADDR_W  upstream instruction address.
REQ-008 if_inst  input  INST_W  upstream instruction word.
REQ-009 if_ready  output  1  stage can accept an entry this cycle; registered.
REQ-010 id_valid  output  1  id_pc/id_inst hold a live entry; registered.
REQ-011 id_pc  output  ADDR_W  downstream instruction address; registered.
REQ-012 id_inst  output  INST_W  downstream instruction word; registered.
REQ-013 id_ready  input  1  downstream accepts the current entry.
REQ-014 bubble_cnt  output  32  bubble-cycle count; present only with IF_ID_BUBBLE_CNT_EN.

Function
REQ-015 Transfer in: if_valid && if_ready at posedge; transfer out: id_valid && id_ready at posedge.
REQ-016 Storage: main register (drives id_*) plus one skid register; states EMPTY, ONE (main only), TWO (main+skid).
REQ-017 if_ready SHALL be 1 in EMPTY and ONE, 0 in TWO; id_valid SHALL be 0 in EMPTY, 1 in ONE and TWO.
REQ-018 EMPTY: if_valid -> load main, go ONE; else stay.
REQ-019 ONE: in and out transfer -> load main with input, stay ONE; in only -> load skid, go TWO; out only -> go EMPTY; neither -> hold.
REQ-020 TWO: out transfer -> main<=skid, go ONE; else hold; no input accepted.
REQ-021 Throughput: one entry per cycle sustained while id_ready==1; latency if_* to id_* is exactly one cycle when EMPTY or ONE with id_ready==1.
REQ-022 Ordering: entries leave in arrival order; none duplicated or dropped except by flush or reset.
REQ-023 In EMPTY, id_pc and id_inst SHALL be all-zero (NOP); in TWO, id_* SHALL be unchanged until the out transfer.
REQ-024 flush==1 at posedge: go EMPTY, id_valid=0, id_pc=id_inst=0, skid cleared, the same-cycle input discarded regardless of if_valid; flush has priority over every transition.
REQ-025 id_ready may toggle freely; id_* SHALL stay stable while id_valid==1 and id_ready==0.
REQ-026 Skid register contents are don't-care outside TWO but SHALL NOT appear on id_*.

Reset
REQ-027 rst==0 SHALL asynchronously force EMPTY: id_valid=0, id_pc=0, id_inst=0, if_ready=1, skid cleared, bubble_cnt=0.
REQ-028 Reset mid-operation SHALL discard all held entries; no entry emerges after release unless newly accepted.
REQ-029 First accept possible at the first posedge with rst==1.

Configuration
REQ-030 Macro IF_ID_BUBBLE_CNT_EN defined: bubble_cnt increments by 1 each posedge where id_valid==0 (after state update is not considered; sampled pre-edge), saturates at 32'hFFFF_FFFF, cleared by reset only (flush does not clear it).
REQ-031 Macro IF_ID_BUBBLE_CNT_EN undefined: bubble_cnt port and counter logic absent; all other behaviour identical.

Verification
REQ-032 Reset, then if_valid=1, if_pc=0x100, if_inst=0x3401_0001, id_ready=1 -> next cycle id_valid=1, id_pc=0x100, id_inst=0x3401_0001.
REQ-033 Stream pc 0x100,0x104,0x108 with id_ready=1 every cycle -> id_pc 0x100,0x104,0x108 on consecutive cycles, if_ready stays 1.
REQ-034 ONE with pc 0x100, id_ready=0, accept 0x104 -> if_ready=0, id_pc=0x100 held; raise id_ready -> 0x100 out, then 0x104, if_ready returns 1.
REQ-035 TWO (0x200 main, 0x204 skid), flush=1 with if_valid=1 pc 0x208 -> next cycle id_valid=0, id_pc=0, id_inst=0, if_ready=1; 0x208 never appears.
REQ-036 Drive rst=0 asynchronously mid-cycle while in TWO -> outputs zero immediately, if_ready=1, no stale entry after release.
REQ-037 With IF_ID_BUBBLE_CNT_EN: 5 idle cycles after reset then 3 valid cycles with id_ready=1 -> bubble_cnt=5 and unchanged during the valid cycles.

Source files
------------

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer, full throughput and registered handshakes.
// Optional bubble-cycle counter enabled by defining IF_ID_BUBBLE_CNT_EN.
module if_id_skid_reg #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              if_ready,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    input  logic              id_ready
`ifdef IF_ID_BUBBLE_CNT_EN
    ,
    output logic [31:0]       bubble_cnt
`endif
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] skid_pc_q;
    logic [INST_W-1:0] skid_inst_q;

    // id_* are the main register; if_ready/id_valid are kept as flops alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StEmpty;
            if_ready    <= 1'b1;
            id_valid    <= 1'b0;
            id_pc       <= '0;
            id_inst     <= '0;
            skid_pc_q   <= '0;
            skid_inst_q <= '0;
        end else if (flush) begin
            state_q     <= StEmpty;
            if_ready    <= 1'b1;
            id_valid    <= 1'b0;
            id_pc       <= '0;
            id_inst     <= '0;
            skid_pc_q   <= '0;
            skid_inst_q <= '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (if_valid) begin
                        state_q  <= StOne;
                        id_valid <= 1'b1;
                        id_pc    <= if_pc;
                        id_inst  <= if_inst;
                    end
                end
                StOne: begin
                    if (if_valid && id_ready) begin
                        id_pc   <= if_pc;
                        id_inst <= if_inst;
                    end else if (if_valid) begin
                        state_q     <= StTwo;
                        if_ready    <= 1'b0;
                        skid_pc_q   <= if_pc;
                        skid_inst_q <= if_inst;
                    end else if (id_ready) begin
                        // Drained: present a NOP on id_*.
                        state_q  <= StEmpty;
                        id_valid <= 1'b0;
                        id_pc    <= '0;
                        id_inst  <= '0;
                    end
                end
                StTwo: begin
                    if (id_ready) begin
                        state_q  <= StOne;
                        if_ready <= 1'b1;
                        id_pc    <= skid_pc_q;
                        id_inst  <= skid_inst_q;
                    end
                end
                default: begin
                    state_q  <= StEmpty;
                    if_ready <= 1'b1;
                    id_valid <= 1'b0;
                    id_pc    <= '0;
                    id_inst  <= '0;
                end
            endcase
        end
    end

`ifdef IF_ID_BUBBLE_CNT_EN
    // Counts edges where no live entry was presented; flush does not clear it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
        end else if (!id_valid && (bubble_cnt != 32'hFFFF_FFFF)) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule
